ex_mdu_seq: RTL and testbench

- Iterative multiply/divide sequencer for the EX stage, covering the RV32M ops.
- Accepts one M-extension request from EX, holds the pipeline with a stall while it computes one bit per cycle, then returns the result for one cycle on the EX output path (muxed into opr_res).
- Contains its own FSM, iteration counter and shift registers; the ALU is not shared.

---
 rtl/ex_mdu_seq_if.sv | 40 ++++
 rtl/ex_mdu_seq.sv | 187 ++++++++++++++++++
 tb/tb_ex_mdu_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_seq_if.sv
// ex_mdu_seq_if: EX-stage <-> multiply/divide sequencer connection.
//
// Handshake: EX raises req with op/opr_a/opr_b and keeps them stable for as
// long as stall is high. The sequencer answers with a single-cycle res_valid
// strobe carrying res. flush kills the in-flight instruction at any time; no
// res_valid is produced for a flushed instruction.
//
// Signals:
//   req       EX -> MDU  valid M-extension op present
//   op        EX -> MDU  funct3 (MUL..REMU)
//   opr_a     EX -> MDU  rs1 value
//   opr_b     EX -> MDU  rs2 value
//   flush     EX -> MDU  instruction killed
//   stall     MDU -> EX  freeze IF/ID/EX
//   res       MDU -> EX  result (meaningful while res_valid)
//   res_valid MDU -> EX  one-cycle result strobe
//   busy      MDU -> EX  sequencer not idle
interface ex_mdu_seq_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic [2:0]      op;
  logic [XLEN-1:0] opr_a;
  logic [XLEN-1:0] opr_b;
  logic            flush;
  logic            stall;
  logic [XLEN-1:0] res;
  logic            res_valid;
  logic            busy;

  modport master (
    output req, op, opr_a, opr_b, flush,
    input  stall, res, res_valid, busy
  );

  modport slave (
    input  req, op, opr_a, opr_b, flush,
    output stall, res, res_valid, busy
  );
endinterface

// File: rtl/ex_mdu_seq.sv
// ex_mdu_seq: iterative RV32M multiply/divide sequencer for the EX stage.
//
// One radix-2 step per cycle on unsigned magnitudes: shift-add for multiply,
// restoring subtraction for divide. Signs are stripped on accept and restored
// by two's-complement negation when the result is presented.
//
// Ports:
//   clk          clock
//   arst_n       asynchronous active-low reset
//   mdu          slave side of ex_mdu_seq_if (req/op/operands/flush in,
//                stall/res/res_valid/busy out)
//   dbg_state_o  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module ex_mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic         clk,
  input  logic         arst_n,
  ex_mdu_seq_if.slave  mdu,
  output logic [1:0]   dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          op_q, op_d;
  logic                sign_q, sign_d;
  // Multiply: {product_hi, multiplier/product_lo}.
  // Divide:   {remainder, dividend/quotient}.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [XLEN-1:0]     res_q, res_d;

  // ---------------------------------------------------------------------
  // Operand decode on accept
  // ---------------------------------------------------------------------
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            sign_in, div_by_zero, div_ovf;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    sign_in  = 1'b0;
    case (mdu.op)
      3'd0, 3'd1, 3'd4, 3'd6: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'd2:                   begin a_signed = 1'b1; end
      default:                ;
    endcase
    a_neg = a_signed & mdu.opr_a[XLEN-1];
    b_neg = b_signed & mdu.opr_b[XLEN-1];
    a_mag = a_neg ? -mdu.opr_a : mdu.opr_a;
    b_mag = b_neg ? -mdu.opr_b : mdu.opr_b;
    case (mdu.op)
      3'd0, 3'd1, 3'd4: sign_in = a_neg ^ b_neg;
      3'd2, 3'd6:       sign_in = a_neg;
      default:          sign_in = 1'b0;
    endcase
    div_by_zero = mdu.op[2] & (mdu.opr_b == '0);
    div_ovf     = ((mdu.op == 3'd4) || (mdu.op == 3'd6)) &&
                  (mdu.opr_a == INT_MIN) && (mdu.opr_b == ALL_ONES);
  end

  // ---------------------------------------------------------------------
  // Datapath step
  // ---------------------------------------------------------------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   rem_diff;
  logic            rem_ge;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
               (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    // Remainder needs one extra bit after the shift since it may reach 2*b-1.
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_ge   = (rem_sh >= {1'b0, b_q});
    rem_diff = rem_ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
  end

  // ---------------------------------------------------------------------
  // Result formatting (valid in DONE)
  // ---------------------------------------------------------------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_fld, div_fix, done_val;

  always_comb begin
    // Multiply negates the full 64-bit product; divide negates only the
    // selected quotient/remainder field.
    prod_fix = sign_q ? -acc_q : acc_q;
    div_fld  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    div_fix  = sign_q ? -div_fld : div_fld;
    if (op_q[2])            done_val = div_fix;
    else if (op_q == 3'd0)  done_val = prod_fix[XLEN-1:0];
    else                    done_val = prod_fix[2*XLEN-1:XLEN];
  end

  // ---------------------------------------------------------------------
  // FSM next-state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (mdu.req && !mdu.flush) begin
          op_d  = mdu.op;
          b_d   = b_mag;
          cnt_d = '0;
          if (div_by_zero) begin
            // Quotient all ones, remainder is the raw dividend.
            acc_d   = {mdu.opr_a, ALL_ONES};
            sign_d  = 1'b0;
            state_d = S_DONE;
          end else if (div_ovf) begin
            acc_d   = {{XLEN{1'b0}}, INT_MIN};
            sign_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, a_mag};
            sign_d  = sign_in;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (mdu.flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[2]) acc_d = {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], rem_ge};
          else         acc_d = {mul_sum, acc_q[XLEN-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!mdu.flush) res_d = done_val;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // DONE releases the pipeline; reset forces stall low even with req held.
  assign mdu.stall     = arst_n & mdu.req & ~mdu.flush & (state_q != S_DONE);
  assign mdu.res_valid = (state_q == S_DONE) & ~mdu.flush;
  assign mdu.res       = mdu.res_valid ? done_val : res_q;
  assign mdu.busy      = (state_q != S_IDLE);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_ex_mdu_seq.sv
// tb_ex_mdu_seq: directed-vector bench for ex_mdu_seq with a result
// scoreboard (expected value and expected strobe cycle per request).
module tb_ex_mdu_seq;
  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst_n;
  logic [1:0] dbg_state;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ex_mdu_seq_if #(.XLEN(XLEN)) mdu_if ();

  ex_mdu_seq #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .mdu         (mdu_if),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];
  int unsigned     exp_cyc_q[$];
  string           exp_name_q[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: sampled mid low-phase, pops one expectation per res_valid.
  initial begin
    logic [XLEN-1:0] e;
    int unsigned     ec;
    string           en;
    forever begin
      @(negedge clk);
      #1;
      if (mdu_if.res_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_res_valid: got res 0x%0h expected no strobe at cycle %0d",
                   mdu_if.res, cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          en = exp_name_q.pop_front();
          check({en, "_res"}, 64'(mdu_if.res), 64'(e));
          check({en, "_cycle"}, 64'(cyc), 64'(ec));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one request and hold it until stall drops; counts stall cycles.
  task automatic issue(input string name, input logic [2:0] op,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] exp, input int exp_stalls);
    int n;
    @(negedge clk);
    mdu_if.req   = 1'b1;
    mdu_if.op    = op;
    mdu_if.opr_a = a;
    mdu_if.opr_b = b;
    mdu_if.flush = 1'b0;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + exp_stalls);
    exp_name_q.push_back(name);
    n = 0;
    #1;
    while (mdu_if.stall === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({name, "_stalls"}, 64'(n), 64'(exp_stalls));
  endtask

  task automatic go_idle(input int cycles);
    @(negedge clk);
    mdu_if.req   = 1'b0;
    mdu_if.flush = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    arst_n       = 1'b0;
    mdu_if.req   = 1'b1;   // held during reset: stall must still read 0
    mdu_if.op    = 3'd0;
    mdu_if.opr_a = 32'd1;
    mdu_if.opr_b = 32'd1;
    mdu_if.flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", 64'(mdu_if.stall), 64'd0);
    check("rst_res_valid", 64'(mdu_if.res_valid), 64'd0);
    check("rst_busy", 64'(mdu_if.busy), 64'd0);
    check("rst_res", 64'(mdu_if.res), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    mdu_if.req = 1'b0;
    arst_n     = 1'b1;
    @(negedge clk);

    // Back-to-back multiplies
    issue("mul_7_m3",     3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    issue("mulh_7_m3",    3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    issue("mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    issue("mulhsu_m1_2",  3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);
    issue("mulh_min_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);

    // Divides
    issue("div_m20_6",    3'd4, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFD, 33);
    issue("rem_m20_6",    3'd6, 32'hFFFF_FFEC, 32'h0000_0006, 32'hFFFF_FFFE, 33);
    issue("rem_20_m6",    3'd6, 32'h0000_0014, 32'hFFFF_FFFA, 32'h0000_0002, 33);
    issue("divu_100_7",   3'd5, 32'd100,       32'd7,         32'd14,        33);
    issue("remu_100_7",   3'd7, 32'd100,       32'd7,         32'd2,         33);
    issue("divu_min_m1",  3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);

    // Special divide cases: single stall cycle
    issue("div_5_0",      3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    issue("rem_5_0",      3'd6, 32'd5,         32'd0,         32'd5,         1);
    issue("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    issue("remu_x_0",     3'd7, 32'h0000_1234, 32'd0,         32'h0000_1234, 1);
    go_idle(2);

    // Flush at BUSY step 10: no result expected
    @(negedge clk);
    mdu_if.req   = 1'b1;
    mdu_if.op    = 3'd5;
    mdu_if.opr_a = 32'd100;
    mdu_if.opr_b = 32'd7;
    repeat (11) @(negedge clk);
    mdu_if.flush = 1'b1;
    #1;
    check("flush_stall", 64'(mdu_if.stall), 64'd0);
    check("flush_state_busy", 64'(dbg_state), 64'd1);
    @(negedge clk);
    mdu_if.flush = 1'b0;
    mdu_if.req   = 1'b0;
    #1;
    check("flush_state_idle", 64'(dbg_state), 64'd0);
    check("flush_busy", 64'(mdu_if.busy), 64'd0);
    issue("divu_9_3", 3'd5, 32'd9, 32'd3, 32'd3, 33);
    go_idle(1);

    // Asynchronous reset in the middle of BUSY
    @(negedge clk);
    mdu_if.req   = 1'b1;
    mdu_if.op    = 3'd0;
    mdu_if.opr_a = 32'd5;
    mdu_if.opr_b = 32'd5;
    repeat (5) @(negedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_state", 64'(dbg_state), 64'd0);
    check("arst_busy", 64'(mdu_if.busy), 64'd0);
    check("arst_stall", 64'(mdu_if.stall), 64'd0);
    check("arst_res_valid", 64'(mdu_if.res_valid), 64'd0);
    check("arst_res", 64'(mdu_if.res), 64'd0);
    @(negedge clk);
    mdu_if.req = 1'b0;
    arst_n     = 1'b1;
    issue("mul_3_4", 3'd0, 32'd3, 32'd4, 32'd12, 33);
    go_idle(4);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
